// File: rtl/gold_chip_packer.sv
// Packs the serial Gold chip stream into W-chip words, queues them in a small FIFO and
// presents them on a valid/ready stream with tlast per code period. Optional: GOLD_PACK_STATS_EN.
module gold_chip_packer #(
    parameter int N          = 63,
    parameter int W          = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clkin,
    input  logic                     rstn,
    input  logic                     chip_i,
    input  logic                     chip_valid_i,
    input  logic                     strobe_i,
    output logic [W-1:0]             m_tdata,
    output logic [$clog2(W+1)-1:0]   m_tcnt,
    output logic                     m_tlast,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     overflow_o,
    input  logic                     ovf_clr_i,
    output logic                     sync_err_o
`ifdef GOLD_PACK_STATS_EN
    ,
    output logic [15:0]              period_cnt_o,
    output logic [15:0]              drop_cnt_o
`endif
);

    localparam int CW = $clog2(W + 1);
    localparam int IW = $clog2(W);
    localparam int PW = $clog2(N + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] W_C     = CW'(W);
    localparam logic [PW-1:0] N_C     = PW'(N);
    localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);

    typedef struct packed {
        logic [W-1:0]  data;
        logic [CW-1:0] cnt;
        logic          last;
    } word_t;

    // ------------------------------------------------------------------
    // Packer and period counter
    // ------------------------------------------------------------------
    logic [W-1:0]  sreg;
    logic [CW-1:0] wcnt;
    logic [PW-1:0] pcnt;

    logic [W-1:0]  sreg_nxt;
    logic [CW-1:0] wcnt_inc;
    logic [PW-1:0] pcnt_inc;
    logic          close;
    logic          sync_err_nxt;
    word_t         word_in;

    always_comb begin
        wcnt_inc = wcnt + 1'b1;
        pcnt_inc = pcnt + 1'b1;
        sreg_nxt = sreg;
        sreg_nxt[wcnt[IW-1:0]] = chip_i;
        close = chip_valid_i && (strobe_i || (wcnt_inc == W_C));
        // A strobe must land exactly on chip N; chip N without a strobe is also an error.
        sync_err_nxt = chip_valid_i && (strobe_i ? (pcnt_inc != N_C) : (pcnt_inc == N_C));
        word_in.data = sreg_nxt;
        word_in.cnt  = wcnt_inc;
        word_in.last = strobe_i;
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            sreg       <= '0;
            wcnt       <= '0;
            pcnt       <= '0;
            sync_err_o <= 1'b0;
        end else begin
            sync_err_o <= sync_err_nxt;
            if (chip_valid_i) begin
                if (close) begin
                    sreg <= '0;
                    wcnt <= '0;
                end else begin
                    sreg <= sreg_nxt;
                    wcnt <= wcnt_inc;
                end
                if (strobe_i || (pcnt_inc == N_C))
                    pcnt <= '0;
                else
                    pcnt <= pcnt_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word fall-through from registered storage)
    // ------------------------------------------------------------------
    word_t         mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] count;

    logic pop;
    logic push;
    logic full;
    logic drop;

    always_comb begin
        pop  = m_tvalid && m_tready;
        full = (count == DEPTH_C);
        // A full FIFO still takes the word when the head leaves in the same cycle.
        push = close && (!full || pop);
        drop = close && !push;
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= word_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr].data;
    assign m_tcnt   = mem[rd_ptr].cnt;
    assign m_tlast  = mem[rd_ptr].last;

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn)
            overflow_o <= 1'b0;
        else if (drop)
            overflow_o <= 1'b1;
        else if (ovf_clr_i)
            overflow_o <= 1'b0;
    end

`ifdef GOLD_PACK_STATS_EN
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            period_cnt_o <= '0;
            drop_cnt_o   <= '0;
        end else begin
            if (push && word_in.last && (period_cnt_o != 16'hFFFF))
                period_cnt_o <= period_cnt_o + 1'b1;
            if (drop && (drop_cnt_o != 16'hFFFF))
                drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gold_chip_packer.sv
// Randomized scoreboard bench for gold_chip_packer: a queue-based model predicts words,
// FIFO occupancy, drops, overflow and sync errors; a monitor checks every presented word.
module tb_gold_chip_packer;

    localparam int N  = 63;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clkin        = 1'b0;
    logic          rstn         = 1'b0;
    logic          chip_i       = 1'b0;
    logic          chip_valid_i = 1'b0;
    logic          strobe_i     = 1'b0;
    logic          m_tready     = 1'b0;
    logic          ovf_clr_i    = 1'b0;
    logic [W-1:0]  m_tdata;
    logic [CW-1:0] m_tcnt;
    logic          m_tlast;
    logic          m_tvalid;
    logic          overflow_o;
    logic          sync_err_o;

    gold_chip_packer #(.N(N), .W(W), .FIFO_DEPTH(D)) dut (
        .clkin        (clkin),
        .rstn         (rstn),
        .chip_i       (chip_i),
        .chip_valid_i (chip_valid_i),
        .strobe_i     (strobe_i),
        .m_tdata      (m_tdata),
        .m_tcnt       (m_tcnt),
        .m_tlast      (m_tlast),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .overflow_o   (overflow_o),
        .ovf_clr_i    (ovf_clr_i),
        .sync_err_o   (sync_err_o)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        int data;
        int cnt;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    bit   cur[$];
    int   pcnt;
    int   occ;
    bit   ovf;
    int   tests;
    int   fails;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: whatever the DUT presents must match the scoreboard head.
    always @(negedge clkin) begin
        if (rstn && m_tvalid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got data %0d with nothing expected (t=%0t)", m_tdata, $time);
            end else begin
                chk("tdata", 32'(m_tdata), exp_q[0].data);
                chk("tcnt",  32'(m_tcnt),  exp_q[0].cnt);
                chk("tlast", 32'(m_tlast), int'(exp_q[0].last));
                if (m_tready)
                    void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; the model is advanced from the packing/period/FIFO rules.
    task automatic step(input bit v, input bit c, input bit s, input bit rdy, input bit clr);
        bit   close;
        bit   pop;
        bit   push;
        bit   drop;
        bit   serr;
        exp_t e;
        chip_valid_i = v;
        chip_i       = c;
        strobe_i     = s;
        m_tready     = rdy;
        ovf_clr_i    = clr;
        pop   = (occ > 0) && rdy;
        close = 1'b0;
        serr  = 1'b0;
        if (v) begin
            cur.push_back(c);
            if (s) begin
                serr = (pcnt + 1 != N);
                pcnt = 0;
            end else if (pcnt + 1 == N) begin
                serr = 1'b1;
                pcnt = 0;
            end else begin
                pcnt++;
            end
            close = s || (cur.size() == W);
        end
        push = close && ((occ < D) || pop);
        drop = close && !push;
        if (close) begin
            e.data = 0;
            foreach (cur[i]) e.data |= int'(cur[i]) << i;
            e.cnt  = cur.size();
            e.last = s;
            if (push)
                exp_q.push_back(e);
            cur.delete();
        end
        @(posedge clkin);
        #1;
        occ = occ - int'(pop) + int'(push);
        if (drop)
            ovf = 1'b1;
        else if (clr)
            ovf = 1'b0;
        chk("tvalid",   32'(m_tvalid),   int'(occ > 0));
        chk("overflow", 32'(overflow_o), int'(ovf));
        chk("sync_err", 32'(sync_err_o), int'(serr));
    endtask

    task automatic do_reset(input int cyc);
        rstn = 1'b0;
        #1;
        chk("async_tvalid", 32'(m_tvalid), 0);
        exp_q.delete();
        cur.delete();
        pcnt = 0;
        occ  = 0;
        ovf  = 1'b0;
        chip_valid_i = 1'b0;
        strobe_i     = 1'b0;
        ovf_clr_i    = 1'b0;
        repeat (cyc) @(posedge clkin);
        #1;
        chk("rst_tdata",    32'(m_tdata),    0);
        chk("rst_tcnt",     32'(m_tcnt),     0);
        chk("rst_tlast",    32'(m_tlast),    0);
        chk("rst_overflow", 32'(overflow_o), 0);
        chk("rst_sync_err", 32'(sync_err_o), 0);
        rstn = 1'b1;
    endtask

    task automatic period_pack();
        for (int i = 1; i <= N; i++)
            step(1'b1, (i % 2) == 1, i == N, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        do_reset(2);

        // Period pack: alternating chips, one full period.
        period_pack();

        // Backpressure: 5 words closed into a 4-deep FIFO, then drain and clear.
        for (int i = 1; i <= 40; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_overflow_set", 32'(overflow_o), 1);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("bp_overflow_clr", 32'(overflow_o), 0);

        // Full FIFO with a pop in the cycle the 5th word closes.
        for (int i = 1; i <= 40; i++)
            step(1'b1, 1'($urandom), 1'b0, i == 40, 1'b0);
        chk("full_pop_no_ovf", 32'(overflow_o), 0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-operation: 2 words queued plus 5 chips in the packer.
        for (int i = 1; i <= 21; i++)
            step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
        do_reset(1);
        period_pack();

        // Sync error: early strobe, then a strobe-less period.
        for (int i = 1; i <= 10; i++)
            step(1'b1, 1'($urandom), i == 10, 1'b1, 1'b0);
        for (int i = 1; i <= N; i++)
            step(1'b1, 1'($urandom), 1'b0, 1'b1, 1'b0);

        // Gapped input: same period as the packing test with idle cycles between chips.
        for (int i = 1; i <= 2 * N; i++) begin
            int k;
            k = (i + 1) / 2;
            step((i % 2) == 1, (k % 2) == 1, ((i % 2) == 1) && (k == N), 1'b1, 1'b0);
        end

        // Random traffic, rare strobes, random backpressure and clears.
        repeat (600)
            step(($urandom % 4) != 0, 1'($urandom), ($urandom % 40) == 0,
                 ($urandom % 3) != 0, ($urandom % 16) == 0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
